seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
//  - Latches a packed hex word, decodes each nibble to segments, scans anodes at a fixed refresh rate.
//  - Per-digit decimal point, per-digit blanking and leading-zero blanking.
//  - Sits between the board-level display pins and any logic presenting a hex number.
// PARAMETERS
//  DIGITS      4       number of digits scanned, legal 1..8
//  CLK_DIV     100000  clk cycles per digit slot, legal >= 3
//  ACTIVE_LOW  1       1: seg/dp/an driven low = lit/on; 0: all outputs inverted
// PORTS
//  clk     in   1          system clock, rising edge
//  reset   in   1          asynchronous, active-high
//  load    in   1          1-cycle strobe: capture value/dp_in/blank_in into shadow
//  value   in   4*DIGITS   nibble k (bits 4k+3:4k) = digit k, digit 0 rightmost
//  dp_in   in   DIGITS     bit k = 1 lights decimal point of digit k
//  blank_in in  DIGITS     bit k = 1 forces digit k dark (seg and dp off)
//  lzb_en  in   1          1 = leading-zero blanking enabled (live, not latched)
//  seg     out  7          seg[0]=a ... seg[6]=g
//  dp      out  1          decimal point of the currently selected digit
//  an      out  DIGITS     anode enables, bit k = digit k
// BEHAVIOUR
//  Reset (async assert):
//   - cnt=0, idx=0, guard=0, shadow regs=0.
//   - seg, dp all off; an all off (all-1 when ACTIVE_LOW=1).
//  Shadow:
//   - On a clk edge with load=1, value/dp_in/blank_in are copied into shadow.
//   - Display reads shadow only; the change is visible from the next registered output update.
//  Refresh counter:
//   - cnt counts 0..CLK_DIV-1 and wraps; tick = (cnt==CLK_DIV-1).
//   - On tick: idx <= (idx==DIGITS-1) ? 0 : idx+1, and guard <= 1.
//   - guard clears on the following edge.
//  Outputs (all registered, updated every edge):
//   - guard=1: an all off, seg/dp off. This is a one-cycle ghosting guard per slot.
//   - Otherwise: only an[idx] on; seg = decode(shadow nibble idx); dp = shadow dp[idx].
//   - Each digit is lit CLK_DIV-1 of every CLK_DIV cycles.
//   - Frame period = DIGITS*CLK_DIV cycles.
//   - First edge after reset release drives digit 0.
//  Decode (active-low form, g..a, hex):
//   0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:18 A:08 b:03 C:46 d:21 E:06 F:0E
//   When ACTIVE_LOW=0, seg, dp and an are the bitwise inverse.
//  Dark digit (an[idx] still driven on, seg and dp off):
//   - shadow blank[idx]=1; or
//   - lzb_en=1, idx>0, and shadow nibbles idx..DIGITS-1 are all zero.
//   - Digit 0 is never dark due to LZB, so an all-zero value shows "0".
//   - dp of a dark digit is also off.
//  Simultaneous events:
//   - load on a tick edge: new shadow used for the new idx.
//   - Reset mid-slot: immediate dark, scan restarts at digit 0.
//  Widths: idx is clog2(DIGITS) bits (min 1); cnt is clog2(CLK_DIV) bits.
// TESTING (DIGITS=4, CLK_DIV=4, ACTIVE_LOW=1)
//  1 Reset held, then released with no load -> an=4'hF, seg=7'h7F, dp=1 during reset.
//    After release: an cycles E,F..,D,F..,B,F..,7 with seg=7'h40 on each digit.
//  2 load value=16'h12AF, dp_in=4'b0100 -> seg sequence F:0E, A:08, 2:24, 1:79.
//    dp=0 only while an=4'hB; each digit lit 3 cycles, an=F 1 cycle between.
//  3 value=16'h0070, lzb_en=1 -> digits 3 and 2 dark (seg=7'h7F, an still pulsed), digit 1=78, digit 0=40.
//    Then value=16'h0000 -> only digit 0 shows 40.
//  4 blank_in=4'b0001, dp_in=4'b0001, value=16'h8888 -> digit 0 seg=7'h7F, dp=1.
//    Other digits seg=7'h00.
//  5 Assert reset while an=4'hB -> same cycle an=F, seg=7'h7F.
//    After release, scan restarts at an=4'hE; shadow is cleared to 0.
//  6 Pulse load on a tick edge with a new value -> the new digit slot shows the new value.
//    No cycle shows a stale/new mix on one digit.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Display bus for seg7_scan_driver: data/strobe inputs from the number source
// and the board-level segment/anode pins.
interface seg7_scan_driver_if #(
   parameter int DIGITS = 4
);
   logic                  load;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dp_in;
   logic [DIGITS-1:0]     blank_in;
   logic                  lzb_en;
   logic [6:0]            seg;
   logic                  dp;
   logic [DIGITS-1:0]     an;

   modport master (
      output load, value, dp_in, blank_in, lzb_en,
      input  seg, dp, an
   );

   modport slave (
      input  load, value, dp_in, blank_in, lzb_en,
      output seg, dp, an
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with shadowed display data,
// per-digit decimal point / blanking, leading-zero blanking and a one-cycle
// anti-ghosting gap at the end of every digit slot.
//
// The gap cycle is the refresh tick itself: outputs are registered from the
// next-state scan index, so the edge that advances the index drives all dark
// and the following edge lights the new digit. Each digit is therefore lit
// CLK_DIV-1 of every CLK_DIV cycles, starting from the first edge after reset.
module seg7_scan_driver #(
   parameter int DIGITS     = 4,
   parameter int CLK_DIV    = 100000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                clk,
   input  logic                reset,
   seg7_scan_driver_if.slave   bus
);

   localparam int              IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int              CNT_W    = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam bit              INV      = (ACTIVE_LOW == 0);

   // Active-low segment pattern, bit order g..a.
   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h18;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] value_q;
   logic [DIGITS-1:0]   dp_q;
   logic [DIGITS-1:0]   blank_q;
   logic [6:0]          seg_q;
   logic                dpo_q;
   logic [DIGITS-1:0]   an_q;

   logic                tick;
   logic                zacc;
   logic [DIGITS-1:0]   zabove;
   logic [3:0]          nib_sel;
   logic                dp_sel;
   logic                blank_sel;
   logic                zero_sel;
   logic                dark;
   logic [6:0]          seg_al;
   logic                dp_al;
   logic [DIGITS-1:0]   an_al;

   assign tick = (cnt_q == CNT_LAST);

   // Slot counter and scan index advance.
   always_comb begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // zabove[k] = shadow nibbles k..DIGITS-1 are all zero.
   always_comb begin
      zacc   = 1'b1;
      zabove = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zacc      = zacc & (value_q[4*k +: 4] == 4'h0);
         zabove[k] = zacc;
      end
   end

   // Select shadow data for the digit being driven next.
   always_comb begin
      nib_sel   = 4'h0;
      dp_sel    = 1'b0;
      blank_sel = 1'b0;
      zero_sel  = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_d == IDX_W'(k)) begin
            nib_sel   = value_q[4*k +: 4];
            dp_sel    = dp_q[k];
            blank_sel = blank_q[k];
            zero_sel  = zabove[k];
         end
      end
      dark = blank_sel | (bus.lzb_en & (idx_d != '0) & zero_sel);
   end

   // Output pattern in active-low form; polarity applied at the register.
   always_comb begin
      seg_al = 7'h7F;
      dp_al  = 1'b1;
      an_al  = '1;
      if (!tick) begin
         for (int k = 0; k < DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
               an_al[k] = 1'b0;
            end
         end
         if (!dark) begin
            seg_al = decode(nib_sel);
            dp_al  = ~dp_sel;
         end
      end
   end

   // Scan state, shadow capture and registered pin outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         value_q <= '0;
         dp_q    <= '0;
         blank_q <= '0;
         seg_q   <= INV ? 7'h00 : 7'h7F;
         dpo_q   <= INV ? 1'b0 : 1'b1;
         an_q    <= INV ? '0 : '1;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         if (bus.load) begin
            value_q <= bus.value;
            dp_q    <= bus.dp_in;
            blank_q <= bus.blank_in;
         end
         seg_q <= INV ? ~seg_al : seg_al;
         dpo_q <= INV ? ~dp_al  : dp_al;
         an_q  <= INV ? ~an_al  : an_al;
      end
   end

   assign bus.seg = seg_q;
   assign bus.dp  = dpo_q;
   assign bus.an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver, DIGITS=4, CLK_DIV=4, ACTIVE_LOW=1.
module tb_seg7_scan_driver;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   seg7_scan_driver_if #(.DIGITS(4)) bus ();

   seg7_scan_driver #(
      .DIGITS     (4),
      .CLK_DIV    (4),
      .ACTIVE_LOW (1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int n, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s step=%0d observed=%h expected=%h", tag, n, obs, exp);
      end
   endtask

   task automatic chk_pins(input string tag, input int n, input logic [3:0] an_e,
                           input logic [6:0] seg_e, input logic dp_e);
      chk({tag, "_an"},  n, {4'h0, bus.an},  {4'h0, an_e});
      chk({tag, "_seg"}, n, {1'b0, bus.seg}, {1'b0, seg_e});
      chk({tag, "_dp"},  n, {7'h0, bus.dp},  {7'h0, dp_e});
   endtask

   // Runs ncyc edges from a frame start (digit 0 next), checking every edge.
   // s0..s3 / dpm are the visible segments and lit decimal points per digit.
   // With do_load, new shadow data is presented for edge 16 (the slot-3 tick).
   task automatic frame(input string tag, input int ncyc,
                        input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3,
                        input logic [3:0] dpm, input bit do_load,
                        input logic [15:0] nv, input logic [3:0] ndp,
                        input logic [3:0] nbl, input logic nlzb);
      logic [6:0] sx [4];
      logic [3:0] one;
      logic [3:0] an_e;
      int slot, pos;
      sx[0] = s0; sx[1] = s1; sx[2] = s2; sx[3] = s3;
      one = 4'b0001;
      for (int n = 1; n <= ncyc; n++) begin
         if (do_load && n == 16) begin
            bus.load     = 1'b1;
            bus.value    = nv;
            bus.dp_in    = ndp;
            bus.blank_in = nbl;
            bus.lzb_en   = nlzb;
         end
         @(posedge clk);
         @(negedge clk);
         bus.load = 1'b0;
         slot = (n - 1) / 4;
         pos  = (n - 1) % 4;
         if (pos == 3) begin
            chk_pins(tag, n, 4'hF, 7'h7F, 1'b1);
         end else begin
            an_e = ~(one << slot);
            chk_pins(tag, n, an_e, sx[slot], ~dpm[slot]);
         end
      end
   endtask

   initial begin
      reset        = 1'b1;
      bus.load     = 1'b0;
      bus.value    = 16'h0;
      bus.dp_in    = 4'h0;
      bus.blank_in = 4'h0;
      bus.lzb_en   = 1'b0;

      @(negedge clk);
      chk_pins("rst_hold", 0, 4'hF, 7'h7F, 1'b1);
      @(negedge clk);
      chk_pins("rst_hold", 1, 4'hF, 7'h7F, 1'b1);
      reset = 1'b0;

      // Cleared shadow shows 0 on every digit; load 12AF on the last tick.
      frame("zero", 16, 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000,
            1'b1, 16'h12AF, 4'b0100, 4'b0000, 1'b0);
      // F A 2 1 with dp on digit 2.
      frame("hex12af", 16, 7'h0E, 7'h08, 7'h24, 7'h79, 4'b0100,
            1'b1, 16'h0070, 4'b0000, 4'b0000, 1'b1);
      // 0070 with leading-zero blanking: digits 3 and 2 dark.
      frame("lzb0070", 16, 7'h40, 7'h78, 7'h7F, 7'h7F, 4'b0000,
            1'b1, 16'h0000, 4'b0000, 4'b0000, 1'b1);
      // All zero with LZB: only digit 0 shows 0.
      frame("lzb0000", 16, 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000,
            1'b1, 16'h8888, 4'b0001, 4'b0001, 1'b0);
      // 8888 with digit 0 blanked; its dp stays off too.
      frame("blank0", 16, 7'h7F, 7'h00, 7'h00, 7'h00, 4'b0000,
            1'b1, 16'h1234, 4'b0000, 4'b0000, 1'b0);
      // 1234 loaded on a tick edge; stop while digit 2 (an=B) is lit.
      frame("hex1234", 9, 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000,
            1'b0, 16'h0, 4'h0, 4'h0, 1'b0);

      #1 reset = 1'b1;
      #1 chk_pins("rst_mid", 0, 4'hF, 7'h7F, 1'b1);
      @(negedge clk);
      chk_pins("rst_mid", 1, 4'hF, 7'h7F, 1'b1);
      reset = 1'b0;

      // Shadow cleared by reset, scan restarts at digit 0.
      frame("after_rst", 16, 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000,
            1'b0, 16'h0, 4'h0, 4'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
